mem_stage: RTL and testbench

Memory-access stage of the RV32I 5-stage pipeline, between the ex_mem register and the mem_wb register. Takes load/store controls, the ALU result (effective address), and the store operand from EX/MEM. Drives a variable-latency, ready-handshaked data-memory port. Produces the formatted load word dm_data_mem, consumed by mem_wb, and a stall_mem signal that freezes the upstream pipeline while an access is outstanding.

---
 rtl/mem_stage.sv | 165 ++++++++++++++++
 tb/tb_mem_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : RV32I memory-access stage with a ready-handshaked data port
// Rev 1.0   : initial release
// ============================================================================
module mem_stage #(
  parameter int DMEM_ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_mem,
  input  logic                   load_mem,
  input  logic                   store_mem,
  input  logic [2:0]             funct3_mem,
  input  logic [31:0]            alu_data_mem,
  input  logic [31:0]            rs2_data_mem,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DMEM_ADDR_W-1:0] dmem_addr,
  output logic [3:0]             dmem_be,
  output logic [31:0]            dmem_wdata,
  input  logic                   dmem_ready,
  input  logic [31:0]            dmem_rdata,
  output logic [31:0]            dm_data_mem,
  output logic                   stall_mem,
  output logic                   misalign_mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        acc;
  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic        start;
  logic        complete;
  logic        stall_c;
  logic        misalign_c;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] word_addr;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;

  // Unused funct3 encodings fall through to word size.
  assign acc        = valid_mem & (load_mem | store_mem);
  assign is_byte    = (funct3_mem[1:0] == 2'b00);
  assign is_half    = (funct3_mem[1:0] == 2'b01);
  assign misaligned = (is_half & alu_data_mem[0]) |
                      (~is_byte & ~is_half & (|alu_data_mem[1:0]));
  assign word_addr  = {alu_data_mem[31:2], 2'b00};

  function automatic logic [31:0] format_load(
    input logic [31:0] rdata,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = rdata >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  format_load = {{24{b[7]}}, b};
      3'b100:  format_load = {24'd0, b};
      3'b001:  format_load = {{16{h[15]}}, h};
      3'b101:  format_load = {16'd0, h};
      default: format_load = rdata;
    endcase
  endfunction

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = 32'd0;
    if (store_mem) begin
      wdata_nxt = rs2_data_mem;
      if (is_byte) begin
        be_nxt    = 4'b0001 << alu_data_mem[1:0];
        wdata_nxt = {4{rs2_data_mem[7:0]}};
      end else if (is_half) begin
        be_nxt    = alu_data_mem[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{rs2_data_mem[15:0]}};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    complete   = 1'b0;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    dmem_req   = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (misaligned) begin
            misalign_c = 1'b1;
          end else begin
            start     = 1'b1;
            stall_c   = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        dmem_req = 1'b1;
        stall_c  = 1'b1;
        if (dmem_ready) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end
      end
      // Instruction is still presented here; returning to IDLE without
      // looking at acc prevents a duplicate access.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stall_mem    = stall_c & ~rst;
  assign misalign_mem = misalign_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= 4'd0;
      dmem_wdata  <= 32'd0;
      ld_funct3   <= 3'd0;
      ld_off      <= 2'd0;
      dm_data_mem <= 32'd0;
    end else begin
      if (start) begin
        dmem_we    <= store_mem;
        dmem_addr  <= word_addr[DMEM_ADDR_W-1:0];
        dmem_be    <= be_nxt;
        dmem_wdata <= wdata_nxt;
        ld_funct3  <= funct3_mem;
        ld_off     <= alu_data_mem[1:0];
      end
      if (complete && !dmem_we) begin
        dm_data_mem <= format_load(dmem_rdata, ld_funct3, ld_off);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : table-driven self-checking bench for mem_stage
// Rev 1.0      : initial release
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_mem, load_mem, store_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] alu_data_mem, rs2_data_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] dm_data_mem;
  logic        stall_mem, misalign_mem;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] last_dm = 32'd0;

  always #5 clk = ~clk;

  mem_stage #(.DMEM_ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .valid_mem(valid_mem), .load_mem(load_mem), .store_mem(store_mem),
    .funct3_mem(funct3_mem), .alu_data_mem(alu_data_mem), .rs2_data_mem(rs2_data_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dm_data_mem(dm_data_mem), .stall_mem(stall_mem), .misalign_mem(misalign_mem)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          dly;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] dm;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rs2,
                              input logic [31:0] rdata, input int dly, input logic mis,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input logic [31:0] dm);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
    v.dly = dly; v.mis = mis; v.be = be; v.wdata = wdata; v.dm = dm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_inputs();
    valid_mem = 1'b0; load_mem = 1'b0; store_mem = 1'b0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0BAD0BAD;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int stalls;
    @(posedge clk); #1;
    valid_mem = 1'b1; load_mem = v.ld; store_mem = v.st; funct3_mem = v.f3;
    alu_data_mem = v.addr; rs2_data_mem = v.rs2;
    dmem_ready = 1'b0; dmem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    if (v.mis) begin
      chk($sformatf("v%0d misalign", idx), {31'd0, misalign_mem}, 32'd1);
      chk($sformatf("v%0d mis_stall", idx), {31'd0, stall_mem}, 32'd0);
      chk($sformatf("v%0d mis_req", idx), {31'd0, dmem_req}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("v%0d mis_req2", idx), {31'd0, dmem_req}, 32'd0);
      chk($sformatf("v%0d mis_dm", idx), dm_data_mem, v.dm);
      @(posedge clk); #1;
      idle_inputs();
    end else begin
      stalls = 0;
      chk($sformatf("v%0d misalign0", idx), {31'd0, misalign_mem}, 32'd0);
      chk($sformatf("v%0d idle_req", idx), {31'd0, dmem_req}, 32'd0);
      if (stall_mem) stalls++;
      for (int k = 0; k <= v.dly; k++) begin
        @(posedge clk); #1;
        dmem_ready = (k == v.dly);
        dmem_rdata = (k == v.dly) ? v.rdata : 32'h0BAD0BAD;
        @(negedge clk);
        chk($sformatf("v%0d req c%0d", idx, k), {31'd0, dmem_req}, 32'd1);
        chk($sformatf("v%0d addr c%0d", idx, k), dmem_addr, v.addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d be", idx), {28'd0, dmem_be}, {28'd0, v.be});
        chk($sformatf("v%0d we", idx), {31'd0, dmem_we}, {31'd0, v.st});
        if (v.st) chk($sformatf("v%0d wdata", idx), dmem_wdata, v.wdata);
        chk($sformatf("v%0d dm_hold c%0d", idx, k), dm_data_mem, last_dm);
        if (stall_mem) stalls++;
      end
      // DONE cycle: ready with junk data must be ignored
      @(posedge clk); #1;
      dmem_ready = 1'b1; dmem_rdata = 32'h5A5A5A5A;
      @(negedge clk);
      if (stall_mem) stalls++;
      chk($sformatf("v%0d done_req", idx), {31'd0, dmem_req}, 32'd0);
      chk($sformatf("v%0d dm", idx), dm_data_mem, v.dm);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk($sformatf("v%0d post_req", idx), {31'd0, dmem_req}, 32'd0);
      chk($sformatf("v%0d post_dm", idx), dm_data_mem, v.dm);
      chk($sformatf("v%0d stall_cycles", idx), stalls, v.dly + 2);
    end
    last_dm = v.dm;
  endtask

  initial begin
    //           ld   st   f3      addr          rs2           rdata        dly mis be       wdata         dm
    vecs[0]  = mk(1'b1, 1'b0, 3'b010, 32'h100, 32'h0,         32'hDEADBEEF, 0, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF);
    vecs[1]  = mk(1'b1, 1'b0, 3'b000, 32'h103, 32'h0,         32'h80FF1234, 0, 1'b0, 4'b1111, 32'h0,        32'hFFFFFF80);
    vecs[2]  = mk(1'b1, 1'b0, 3'b100, 32'h103, 32'h0,         32'h80FF1234, 0, 1'b0, 4'b1111, 32'h0,        32'h00000080);
    vecs[3]  = mk(1'b1, 1'b0, 3'b001, 32'h102, 32'h0,         32'h80FF1234, 0, 1'b0, 4'b1111, 32'h0,        32'hFFFF80FF);
    vecs[4]  = mk(1'b1, 1'b0, 3'b101, 32'h100, 32'h0,         32'h80FF1234, 1, 1'b0, 4'b1111, 32'h0,        32'h00001234);
    vecs[5]  = mk(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB,  32'hFFFFFFFF, 0, 1'b0, 4'b0010, 32'hABABABAB, 32'h00001234);
    vecs[6]  = mk(1'b0, 1'b1, 3'b001, 32'h202, 32'h00001234,  32'hFFFFFFFF, 0, 1'b0, 4'b1100, 32'h12341234, 32'h00001234);
    vecs[7]  = mk(1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D,  32'hFFFFFFFF, 2, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h00001234);
    vecs[8]  = mk(1'b1, 1'b0, 3'b010, 32'h300, 32'h0,         32'h11228344, 3, 1'b0, 4'b1111, 32'h0,        32'h11228344);
    vecs[9]  = mk(1'b1, 1'b0, 3'b000, 32'h301, 32'h0,         32'h11228344, 0, 1'b0, 4'b1111, 32'h0,        32'hFFFFFF83);
    vecs[10] = mk(1'b1, 1'b0, 3'b101, 32'h102, 32'h0,         32'h11228344, 0, 1'b0, 4'b1111, 32'h0,        32'h00001122);
    vecs[11] = mk(1'b1, 1'b0, 3'b110, 32'h108, 32'h0,         32'h55667788, 0, 1'b0, 4'b1111, 32'h0,        32'h55667788);
    vecs[12] = mk(1'b0, 1'b1, 3'b011, 32'h10C, 32'h01020304,  32'hFFFFFFFF, 0, 1'b0, 4'b1111, 32'h01020304, 32'h55667788);
    vecs[13] = mk(1'b0, 1'b1, 3'b000, 32'h203, 32'h1234567F,  32'hFFFFFFFF, 1, 1'b0, 4'b1000, 32'h7F7F7F7F, 32'h55667788);
    vecs[14] = mk(1'b1, 1'b0, 3'b001, 32'h100, 32'h0,         32'h00007FFF, 0, 1'b0, 4'b1111, 32'h0,        32'h00007FFF);
    vecs[15] = mk(1'b1, 1'b0, 3'b010, 32'h102, 32'h0,         32'h0,        0, 1'b1, 4'b1111, 32'h0,        32'h00007FFF);
    vecs[16] = mk(1'b1, 1'b0, 3'b001, 32'h101, 32'h0,         32'h0,        0, 1'b1, 4'b1111, 32'h0,        32'h00007FFF);
    vecs[17] = mk(1'b0, 1'b1, 3'b010, 32'h203, 32'h0,         32'h0,        0, 1'b1, 4'b1111, 32'h0,        32'h00007FFF);
    vecs[18] = mk(1'b0, 1'b1, 3'b001, 32'h205, 32'h0,         32'h0,        0, 1'b1, 4'b1111, 32'h0,        32'h00007FFF);

    // Reset held with a valid aligned load presented: everything quiet
    rst = 1'b1;
    valid_mem = 1'b1; load_mem = 1'b1; store_mem = 1'b0; funct3_mem = 3'b010;
    alu_data_mem = 32'h100; rs2_data_mem = 32'hFFFFFFFF;
    dmem_ready = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst req", {31'd0, dmem_req}, 32'd0);
    chk("rst stall", {31'd0, stall_mem}, 32'd0);
    chk("rst misalign", {31'd0, misalign_mem}, 32'd0);
    chk("rst dm", dm_data_mem, 32'd0);
    chk("rst addr", dmem_addr, 32'd0);
    chk("rst be", {28'd0, dmem_be}, 32'd0);
    chk("rst we", {31'd0, dmem_we}, 32'd0);
    chk("rst wdata", dmem_wdata, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Reset mid-REQ with ready high: access discarded, no capture
    @(posedge clk); #1;
    valid_mem = 1'b1; load_mem = 1'b1; store_mem = 1'b0; funct3_mem = 3'b010;
    alu_data_mem = 32'h400;
    @(posedge clk); #1;
    dmem_ready = 1'b1; dmem_rdata = 32'hAAAA5555;
    @(negedge clk);
    chk("midrst pre_req", {31'd0, dmem_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst req", {31'd0, dmem_req}, 32'd0);
    chk("midrst dm", dm_data_mem, 32'd0);
    chk("midrst stall", {31'd0, stall_mem}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    chk("postrst req", {31'd0, dmem_req}, 32'd0);
    chk("postrst stall", {31'd0, stall_mem}, 32'd0);
    chk("postrst dm", dm_data_mem, 32'd0);
    last_dm = 32'd0;
    run_vec(mk(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h13579BDF, 0, 1'b0, 4'b1111, 32'h0, 32'h13579BDF), 99);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
